// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/exception inputs from the datapath and the
// stall/flush/redirect controls plus debug counters returned to it.
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [15:0] exc_count;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_from_id, stallreq_from_ex, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, exc_count, stall_cycles
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, exc_count, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges ID/EX stall requests, takes MEM exceptions with a
// programmable flush window, and keeps stall-timeout and event counters.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave pif
);
  localparam logic [31:0]      ERET_CODE = 32'h0000000e;
  localparam int unsigned      RUN_W     = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_TRIP  = RUN_W'(STALL_TIMEOUT - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [3:0]       flush_cnt, flush_cnt_nxt;
  logic [31:0]      new_pc_q;
  logic [31:0]      target;
  logic             take_exc;
  logic [RUN_W-1:0] stall_run;

  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             stall_timeout;
  logic [15:0]      exc_count;
  logic [31:0]      stall_cycles;
  logic             stalled;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    stall         = '0;
    flush         = 1'b0;
    new_pc        = '0;
    take_exc      = 1'b0;
    target        = (pif.excepttype_i == ERET_CODE) ? pif.cp0_epc_i : EXC_VECTOR;
    // Outputs are gated by reset so an asserted rst silences flush/stall at once.
    if (rst) begin
      unique case (state)
        RUN: begin
          if (pif.excepttype_i != '0) begin
            flush    = 1'b1;
            new_pc   = target;
            take_exc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt     = FLUSH;
              flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
            end
          end else if (pif.stallreq_from_ex) begin
            stall = 6'b001111;
          end else if (pif.stallreq_from_id) begin
            stall = 6'b000111;
          end
        end
        FLUSH: begin
          flush         = 1'b1;
          new_pc        = new_pc_q;
          flush_cnt_nxt = flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign stalled = (stall != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      new_pc_q  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (take_exc) new_pc_q <= target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_run     <= '0;
      stall_timeout <= 1'b0;
      exc_count     <= '0;
      stall_cycles  <= '0;
    end else begin
      if (stalled) begin
        stall_cycles <= stall_cycles + 32'd1;
        if (stall_run != RUN_MAX) stall_run <= stall_run + 1'b1;
        if (stall_run == RUN_TRIP) stall_timeout <= 1'b1;
      end else begin
        stall_run <= '0;
      end
      if (take_exc && (exc_count != '1)) exc_count <= exc_count + 16'd1;
    end
  end

  assign pif.stall         = stall;
  assign pif.flush         = flush;
  assign pif.new_pc        = new_pc;
  assign pif.stall_timeout = stall_timeout;
  assign pif.exc_count     = exc_count;
  assign pif.stall_cycles  = stall_cycles;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (single-cycle flush / long timeout, and
// three-cycle flush / short timeout) checked against a cycle-level reference model.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_id, in_ex;
  logic [31:0] in_exc, in_epc;

  pipe_ctrl_if ia ();
  pipe_ctrl_if ib ();

  assign ia.stallreq_from_id = in_id;
  assign ia.stallreq_from_ex = in_ex;
  assign ia.excepttype_i     = in_exc;
  assign ia.cp0_epc_i        = in_epc;
  assign ib.stallreq_from_id = in_id;
  assign ib.stallreq_from_ex = in_ex;
  assign ib.excepttype_i     = in_exc;
  assign ib.cp0_epc_i        = in_epc;

  pipe_ctrl #(.FLUSH_CYCLES(1), .EXC_VECTOR(32'h00000020), .STALL_TIMEOUT(1024))
    u_a (.clk(clk), .rst(rst), .pif(ia));
  pipe_ctrl #(.FLUSH_CYCLES(3), .EXC_VECTOR(32'h00000020), .STALL_TIMEOUT(4))
    u_b (.clk(clk), .rst(rst), .pif(ib));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: remaining flush cycles after the current one, saved target,
  // length of the current stall run, and the observable counters.
  int unsigned m_left[2];
  logic [31:0] m_tgt[2];
  int unsigned m_run[2];
  logic        m_tmo[2];
  int unsigned m_exc[2];
  logic [31:0] m_sc[2];

  function automatic int unsigned p_flush(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned p_tmo(int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_tgt[k] = '0; m_run[k] = 0;
      m_tmo[k] = 1'b0; m_exc[k] = 0; m_sc[k] = '0;
    end
  endtask

  task automatic model_comb(input int k, output logic [5:0] st, output logic fl,
                            output logic [31:0] npc);
    st = '0; fl = 1'b0; npc = '0;
    if (m_left[k] > 0) begin
      fl = 1'b1; npc = m_tgt[k];
    end else if (in_exc != 32'h0) begin
      fl = 1'b1; npc = (in_exc == 32'he) ? in_epc : 32'h20;
    end else if (in_ex) begin
      st = 6'h0f;
    end else if (in_id) begin
      st = 6'h07;
    end
  endtask

  task automatic model_update(input int k);
    logic [5:0] st; logic fl; logic [31:0] npc;
    model_comb(k, st, fl, npc);
    if (m_left[k] > 0) m_left[k]--;
    else if (in_exc != 32'h0) begin
      m_left[k] = p_flush(k) - 1;
      m_tgt[k]  = npc;
      if (m_exc[k] < 65535) m_exc[k]++;
    end
    if (st != 6'h0) begin
      m_run[k]++;
      if (m_run[k] >= p_tmo(k)) m_tmo[k] = 1'b1;
      m_sc[k] = m_sc[k] + 32'd1;
    end else begin
      m_run[k] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic dut_out(input int k, output logic [5:0] st, output logic fl,
                         output logic [31:0] npc, output logic tmo,
                         output logic [15:0] ec, output logic [31:0] sc);
    if (k == 0) begin
      st = ia.stall; fl = ia.flush; npc = ia.new_pc;
      tmo = ia.stall_timeout; ec = ia.exc_count; sc = ia.stall_cycles;
    end else begin
      st = ib.stall; fl = ib.flush; npc = ib.new_pc;
      tmo = ib.stall_timeout; ec = ib.exc_count; sc = ib.stall_cycles;
    end
  endtask

  task automatic compare_all();
    logic [5:0] est, st; logic efl, fl; logic [31:0] enpc, npc, sc;
    logic tmo; logic [15:0] ec; string p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? "a" : "b";
      model_comb(k, est, efl, enpc);
      dut_out(k, st, fl, npc, tmo, ec, sc);
      chk({p, ".stall"}, 32'(st), 32'(est));
      chk({p, ".flush"}, 32'(fl), 32'(efl));
      chk({p, ".new_pc"}, npc, enpc);
      chk({p, ".stall_timeout"}, 32'(tmo), 32'(m_tmo[k]));
      chk({p, ".exc_count"}, 32'(ec), m_exc[k]);
      chk({p, ".stall_cycles"}, sc, m_sc[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    tick();
  endtask

  task automatic set_in(input logic id, input logic ex, input logic [31:0] exc,
                        input logic [31:0] epc);
    in_id = id; in_ex = ex; in_exc = exc; in_epc = epc;
  endtask

  typedef struct {
    logic        id;
    logic        ex;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl[12];
  int   burst;
  int unsigned base_exc;
  int unsigned r;

  initial begin
    // Expectations for instance a (single-cycle flush), one row per clock.
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 32'h0,    6'h07, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 32'h0,    6'h00, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0, 32'h0,    6'h0f, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0, 32'h0,    6'h0f, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'h0, 32'h0,    6'h0f, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 32'h0,    6'h00, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h8, 32'h0,    6'h00, 1'b1, 32'h20};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 32'h0,    6'h00, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'he, 32'h1000, 6'h00, 1'b1, 32'h1000};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 32'h1000, 6'h00, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0, 32'h0,    6'h07, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h0, 32'h0,    6'h0f, 1'b0, 32'h0};

    model_reset();
    rst = 1'b0;
    set_in(1'b0, 1'b1, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset a.stall", 32'(ia.stall), 32'h0);
    chk("reset b.stall", 32'(ib.stall), 32'h0);
    chk("reset a.flush", 32'(ia.flush), 32'h0);
    chk("reset a.counters", {15'h0, ia.stall_timeout, ia.exc_count}, 32'h0);
    chk("reset a.stall_cycles", ia.stall_cycles, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].id, tbl[i].ex, tbl[i].exc, tbl[i].epc);
      @(negedge clk);
      chk($sformatf("tbl[%0d] stall", i), 32'(ia.stall), 32'(tbl[i].st));
      chk($sformatf("tbl[%0d] flush", i), 32'(ia.flush), 32'(tbl[i].fl));
      chk($sformatf("tbl[%0d] new_pc", i), ia.new_pc, tbl[i].npc);
      if (i == 5) chk("tbl stall_cycles after ID+both", ia.stall_cycles, 32'd4);
      if (i == 7) chk("tbl exc_count after syscall", 32'(ia.exc_count), 32'd1);
      compare_all();
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("tbl final stall_cycles", ia.stall_cycles, 32'd6);
    chk("tbl final exc_count", 32'(ia.exc_count), 32'd2);
    chk("tbl final timeout", 32'(ia.stall_timeout), 32'd0);
    compare_all();
    tick();

    // ERET held three cycles on the three-cycle-flush instance.
    for (int g = 0; g < 8 && m_left[1] != 0; g++) cycle();
    base_exc = m_exc[1];
    for (int j = 0; j < 3; j++) begin
      set_in(1'b0, 1'b0, 32'he, 32'h1000);
      @(negedge clk);
      chk($sformatf("eret flush c%0d", j), 32'(ib.flush), 32'h1);
      chk($sformatf("eret new_pc c%0d", j), ib.new_pc, 32'h1000);
      compare_all();
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("eret flush end", 32'(ib.flush), 32'h0);
    chk("eret exc_count", 32'(ib.exc_count), base_exc + 1);
    compare_all();
    tick();

    // EX stall held five cycles against a timeout of four.
    for (int j = 1; j <= 5; j++) begin
      set_in(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("timeout stall c%0d", j), 32'(ib.stall), 32'h0f);
      chk($sformatf("timeout flag c%0d", j), 32'(ib.stall_timeout), (j >= 5) ? 32'h1 : 32'h0);
      compare_all();
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("timeout sticky", 32'(ib.stall_timeout), 32'h1);
      compare_all();
      tick();
    end

    // Asynchronous reset while instance b is inside its flush window.
    set_in(1'b0, 1'b0, 32'h8, 32'h0);
    cycle();
    set_in(1'b1, 1'b1, 32'he, 32'h1234);
    #1;
    chk("pre-reset b.flush", 32'(ib.flush), 32'h1);
    rst = 1'b0;
    #1;
    chk("async b.flush", 32'(ib.flush), 32'h0);
    chk("async b.new_pc", ib.new_pc, 32'h0);
    chk("async b.stall", 32'(ib.stall), 32'h0);
    chk("async b.stall_timeout", 32'(ib.stall_timeout), 32'h0);
    chk("async b.exc_count", 32'(ib.exc_count), 32'h0);
    chk("async b.stall_cycles", ib.stall_cycles, 32'h0);
    chk("async a.flush", 32'(ia.flush), 32'h0);
    model_reset();
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    repeat (3) cycle();

    // Randomised traffic: ID hazards, EX bursts, sporadic exceptions.
    burst = 0;
    for (int n = 0; n < 400; n++) begin
      in_id = ($urandom_range(0, 3) == 0);
      if (burst > 0) begin
        in_ex = 1'b1;
        burst--;
      end else begin
        in_ex = 1'b0;
        if ($urandom_range(0, 5) == 0) burst = int'($urandom_range(1, 7));
      end
      r = $urandom_range(0, 15);
      in_exc = (r == 0) ? 32'h8 : (r == 1) ? 32'he : (r == 2) ? $urandom : 32'h0;
      in_epc = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
